// File: rtl/debug_step_controller.sv
// rtl/debug_step_controller.sv - CPU pipeline clock-enable generator: auto run or debounced single-step.
// Optional burst stepping on KEY[1] is built when BURST_STEP_EN is defined.
module debug_step_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_DIV        = 1,
    parameter int BURST_LEN       = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             manual_mode,
    input  logic             key_step_n,
    input  logic             key_burst_n,
    output logic             cpu_clk_en,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(AUTO_DIV + 1);

`ifdef BURST_STEP_EN
    localparam int NK    = 2;
    localparam int REM_W = $clog2(BURST_LEN + 1);
    typedef enum logic [1:0] {S_IDLE, S_STEP, S_BURST} state_t;
`else
    localparam int NK    = 1;
    typedef enum logic [0:0] {S_IDLE, S_STEP} state_t;
`endif

    // Bit 0 is the step key, bit 1 (when built) the burst key.
    logic [NK-1:0] key_raw;
`ifdef BURST_STEP_EN
    assign key_raw = {key_burst_n, key_step_n};
`else
    logic unused_burst;
    assign key_raw      = key_step_n;
    assign unused_burst = key_burst_n;
`endif

    logic [1:0]      mode_sync_q, mode_sync_d;
    logic            mode_prev_q, mode_prev_d;
    logic [NK-1:0]   key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [NK-1:0]   stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [DB_W-1:0] db_cnt_q [NK];
    logic [DB_W-1:0] db_cnt_d [NK];
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t          state_q, state_d;
    logic [NK-1:0]   press;
    logic            mode;
    logic            en;
`ifdef BURST_STEP_EN
    logic [REM_W-1:0] rem_q, rem_d;
`endif

    always_comb begin
        mode_sync_d   = {mode_sync_q[0], manual_mode};
        mode_prev_d   = mode_sync_q[1];
        key_s1_d      = key_raw;
        key_s2_d      = key_s1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int k = 0; k < NK; k++) begin
            db_cnt_d[k] = '0;
            if (key_s2_q[k] != stable_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1))
                    stable_d[k] = key_s2_q[k];
                else
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
        end
        // Only the released->pressed transition of the debounced key is an event.
        press = stable_prev_q & ~stable_q;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        en      = 1'b0;
        mode    = mode_sync_q[1];
`ifdef BURST_STEP_EN
        rem_d   = rem_q;
`endif
        if (mode != mode_prev_q) begin
            // One quiet cycle on every mode switch; both sides restart clean.
            state_d = S_IDLE;
            div_d   = '0;
        end else if (!mode) begin
            state_d = S_IDLE;
            if (div_q == DIV_W'(AUTO_DIV - 1)) begin
                div_d = '0;
                en    = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef BURST_STEP_EN
                    if (press[1]) begin
                        state_d = S_BURST;
                        rem_d   = REM_W'(BURST_LEN - 1);
                    end else
`endif
                    if (press[0]) state_d = S_STEP;
                end
                S_STEP: begin
                    en      = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef BURST_STEP_EN
                S_BURST: begin
                    en = 1'b1;
                    if (rem_q == '0) state_d = S_IDLE;
                    else             rem_d   = rem_q - 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        cnt_d = cnt_q + CNT_W'(en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_q   <= '0;
            mode_prev_q   <= 1'b0;
            key_s1_q      <= '1;
            key_s2_q      <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            for (int k = 0; k < NK; k++) db_cnt_q[k] <= '0;
            div_q         <= '0;
            cnt_q         <= '0;
            state_q       <= S_IDLE;
`ifdef BURST_STEP_EN
            rem_q         <= '0;
`endif
        end else begin
            mode_sync_q   <= mode_sync_d;
            mode_prev_q   <= mode_prev_d;
            key_s1_q      <= key_s1_d;
            key_s2_q      <= key_s2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int k = 0; k < NK; k++) db_cnt_q[k] <= db_cnt_d[k];
            div_q         <= div_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
`ifdef BURST_STEP_EN
            rem_q         <= rem_d;
`endif
        end
    end

    assign cpu_clk_en = en;
    assign step_count = cnt_q;
`ifdef BURST_STEP_EN
    assign busy = (state_q == S_BURST);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_debug_step_controller.sv
// tb/tb_debug_step_controller.sv - randomized self-checking bench for debug_step_controller.
module tb_debug_step_controller;
    localparam int D  = 4;
    localparam int AD = 3;
    localparam int BL = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          manual_mode = 1'b0;
    logic          key_step_n = 1'b1;
    logic          key_burst_n = 1'b1;
    logic          cpu_clk_en;
    logic          busy;
    logic [CW-1:0] step_count;

    int chk  = 0;
    int pass = 0;
    int seen = 0;

    debug_step_controller #(
        .DEBOUNCE_CYCLES(D), .AUTO_DIV(AD), .BURST_LEN(BL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .manual_mode(manual_mode),
        .key_step_n(key_step_n), .key_burst_n(key_burst_n),
        .cpu_clk_en(cpu_clk_en), .busy(busy), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        if (cpu_clk_en === 1'b1) seen++;
    endtask

    task automatic do_reset(input logic m);
        tick();
        rst_n = 1'b0;
        manual_mode = m;
        key_step_n = 1'b1;
        key_burst_n = 1'b1;
        tick();
        tick();
        seen = 0;
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic press_step(input int low, input int high);
        key_step_n = 1'b0;
        repeat (low) tick();
        key_step_n = 1'b1;
        repeat (high) tick();
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        chk++; if (cpu_clk_en !== 1'b0) $display("FAIL reset_en: got %b expected 0", cpu_clk_en); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass++;
        chk++; if (step_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", step_count); else pass++;
        rst_n = 1'b1;
    endtask

    // Latency from raw key low: 2 sync stages, D samples to accept, 1 cycle to the pulse.
    task automatic test_manual_hold();
        int first_at = -1;
        do_reset(1'b1);
        key_step_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_clk_en === 1'b1 && first_at < 0) first_at = i;
        end
        key_step_n = 1'b1;
        repeat (10) tick();
        chk++; if (seen != 1) $display("FAIL hold_pulses: got %0d expected 1", seen); else pass++;
        chk++; if (first_at != D + 3) $display("FAIL hold_latency: got %0d expected %0d", first_at, D + 3); else pass++;
        chk++; if (step_count !== 4'd1) $display("FAIL hold_count: got %0d expected 1", step_count); else pass++;
    endtask

    task automatic test_glitch();
        do_reset(1'b1);
        repeat (5) press_step(2, 6);
        chk++; if (seen != 0) $display("FAIL glitch_pulses: got %0d expected 0", seen); else pass++;
        chk++; if (step_count !== 4'd0) $display("FAIL glitch_count: got %0d expected 0", step_count); else pass++;
    endtask

    // A low run is a press iff it lasts at least D samples; highs are long enough to re-arm.
    task automatic test_manual_random();
        int exp_presses = 0;
        do_reset(1'b1);
        for (int s = 0; s < 14; s++) begin
            int l = $urandom_range(2 * D, 1);
            int h = $urandom_range(D + 6, D + 2);
            if (l >= D) exp_presses++;
            press_step(l, h);
        end
        repeat (4) tick();
        chk++; if (seen != exp_presses) $display("FAIL rand_pulses: got %0d expected %0d", seen, exp_presses); else pass++;
        chk++; if (step_count !== CW'(exp_presses)) $display("FAIL rand_count: got %0d expected %0d", step_count, CW'(exp_presses)); else pass++;
    endtask

    task automatic test_auto();
        int n = 0;
        int last = -1;
        int bad_gaps = 0;
        int busy_hi = 0;
        do_reset(1'b0);
        for (int i = 0; i < 30; i++) begin
            key_step_n  = 1'($urandom_range(1, 0));
            key_burst_n = 1'($urandom_range(1, 0));
            tick();
            if (busy !== 1'b0) busy_hi++;
            if (cpu_clk_en === 1'b1) begin
                if (last >= 0 && i - last != AD) bad_gaps++;
                last = i;
                n++;
            end
        end
        key_step_n = 1'b1;
        key_burst_n = 1'b1;
        chk++; if (n != 30 / AD) $display("FAIL auto_pulses: got %0d expected %0d", n, 30 / AD); else pass++;
        chk++; if (bad_gaps != 0) $display("FAIL auto_period: got %0d bad gaps expected 0", bad_gaps); else pass++;
        chk++; if (busy_hi != 0) $display("FAIL auto_busy: got %0d busy cycles expected 0", busy_hi); else pass++;
        chk++; if (step_count !== CW'(seen)) $display("FAIL auto_count: got %0d expected %0d", step_count, CW'(seen)); else pass++;
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        chk++; if (step_count !== 4'd0) $display("FAIL wrap_start: got %0d expected 0", step_count); else pass++;
        repeat (17) press_step(D + 2, D + 4);
        repeat (4) tick();
        chk++; if (seen != 17) $display("FAIL wrap_pulses: got %0d expected 17", seen); else pass++;
        chk++; if (step_count !== 4'd1) $display("FAIL wrap_count: got %0d expected 1", step_count); else pass++;
    endtask

`ifdef BURST_STEP_EN
    task automatic test_burst(input logic both);
        int first = -1;
        int last = -1;
        int busy_n = 0;
        do_reset(1'b1);
        key_burst_n = 1'b0;
        if (both) key_step_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 6) key_burst_n = 1'b1;
            if (!both && i == 3) key_step_n = 1'b0;
            if (i == 9) key_step_n = 1'b1;
            if (busy === 1'b1) busy_n++;
            if (cpu_clk_en === 1'b1) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        chk++; if (seen != BL) $display("FAIL burst_pulses(%0d): got %0d expected %0d", both, seen, BL); else pass++;
        chk++; if (last - first + 1 != BL) $display("FAIL burst_run(%0d): got %0d expected %0d", both, last - first + 1, BL); else pass++;
        chk++; if (busy_n != BL) $display("FAIL burst_busy(%0d): got %0d expected %0d", both, busy_n, BL); else pass++;
        chk++; if (step_count !== CW'(BL)) $display("FAIL burst_count(%0d): got %0d expected %0d", both, step_count, BL); else pass++;
    endtask
`else
    task automatic test_burst_ignored();
        int busy_n = 0;
        do_reset(1'b1);
        key_burst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 10) key_burst_n = 1'b1;
            if (busy !== 1'b0) busy_n++;
        end
        chk++; if (seen != 0) $display("FAIL noburst_pulses: got %0d expected 0", seen); else pass++;
        chk++; if (busy_n != 0) $display("FAIL noburst_busy: got %0d expected 0", busy_n); else pass++;
    endtask
`endif

    // Start a burst when built, otherwise sit idle, then switch to auto mode.
    task automatic start_activity();
`ifdef BURST_STEP_EN
        int guard = 0;
        key_burst_n = 1'b0;
        while (seen < 3 && guard < 40) begin
            tick();
            guard++;
        end
        chk++; if (seen < 3) $display("FAIL burst_start_timeout: got %0d pulses expected 3", seen); else pass++;
`else
        repeat (10) tick();
`endif
    endtask

    task automatic test_mode_change();
        logic [5:0] en_seen;
        logic       busy_k3;
        do_reset(1'b1);
        start_activity();
        manual_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            en_seen[k] = cpu_clk_en;
            if (k == 3) busy_k3 = busy;
        end
        key_burst_n = 1'b1;
        chk++; if (en_seen[4:2] !== 3'b000) $display("FAIL mode_quiet: got %b expected 000", en_seen[4:2]); else pass++;
        chk++; if (busy_k3 !== 1'b0) $display("FAIL mode_busy: got %b expected 0", busy_k3); else pass++;
        chk++; if (en_seen[5] !== 1'b1) $display("FAIL mode_auto_restart: got %b expected 1", en_seen[5]); else pass++;
        do_reset(1'b1);
        start_activity();
        #2 rst_n = 1'b0;
        #1;
        chk++; if (cpu_clk_en !== 1'b0) $display("FAIL async_en: got %b expected 0", cpu_clk_en); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL async_busy: got %b expected 0", busy); else pass++;
        chk++; if (step_count !== 4'd0) $display("FAIL async_count: got %0d expected 0", step_count); else pass++;
        key_burst_n = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_manual_hold();
        test_glitch();
        test_manual_random();
        test_auto();
        test_wrap();
`ifdef BURST_STEP_EN
        test_burst(1'b0);
        test_burst(1'b1);
`else
        test_burst_ignored();
`endif
        test_mode_change();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
